fpmul_pipe_hs: RTL and testbench

FPMUL_PIPE_HS -- requirements
Module: fpmul_pipe_hs

---
 rtl/fpmul_pipe_hs.sv | 182 ++++++++++++++++++
 tb/tb_fpmul_pipe_hs.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_pipe_hs.sv
// fpmul_pipe_hs: pipelined IEEE-754 multiply front end with valid/ready
// handshake and per-stage flush.
//
// Stage 0 latches operand-derived data (sign, biased exponent sum, both
// significands, class flags, rm, tag). Stage 1 latches the full significand
// product. Any further stages are pure delay. The last stage drives out_*.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    upstream handshake; a, b operands; rm, tag_i sideband
//   flush[k]             kill stage k at the next edge
//   out_valid/out_ready  downstream handshake
//   out_sign/out_exp/out_prod/out_rm/out_tag, out_nan/out_inf/out_zero/out_invalid
//   stage_valid, stage_tag  per-stage occupancy and tag
module fpmul_pipe_hs #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 2,
  parameter int TAG_W  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [EXP_W+MAN_W:0]           a,
  input  logic [EXP_W+MAN_W:0]           b,
  input  logic [2:0]                     rm,
  input  logic [TAG_W-1:0]               tag_i,
  input  logic [STAGES-1:0]              flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_sign,
  output logic signed [EXP_W+1:0]        out_exp,
  output logic [2*MAN_W+1:0]             out_prod,
  output logic [2:0]                     out_rm,
  output logic [TAG_W-1:0]               out_tag,
  output logic                           out_nan,
  output logic                           out_inf,
  output logic                           out_zero,
  output logic                           out_invalid,
  output logic [STAGES-1:0]              stage_valid,
  output logic [STAGES-1:0][TAG_W-1:0]   stage_tag
);

  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int EW     = EXP_W + 2;
  localparam logic [EW-1:0] BIAS = EW'(2**(EXP_W-1) - 1);

  if (STAGES < 2 || STAGES > 6) begin : g_bad_stages
    $error("fpmul_pipe_hs: STAGES must be in 2..6");
  end

  // In stage 0 the prod field carries {sig_a, sig_b}; from stage 1 on it
  // carries their product. Both are exactly PROD_W bits wide.
  typedef struct packed {
    logic                 sign;
    logic signed [EW-1:0] expo;
    logic [PROD_W-1:0]    prod;
    logic [2:0]           rm;
    logic [TAG_W-1:0]     tag;
    logic                 nan;
    logic                 inf;
    logic                 zero;
    logic                 invalid;
  } pl_t;

  logic [STAGES-1:0] r_valid;
  pl_t               r_pl [STAGES];

  logic [STAGES-1:0] w_adv;
  logic              w_accept;
  pl_t               w_in_pl;
  pl_t               w_s1_pl;
  logic [PROD_W-1:0] w_prod;

  logic [EXP_W-1:0]  w_ea, w_eb;
  logic [MAN_W-1:0]  w_fa, w_fb;
  logic [EW-1:0]     w_ea_x, w_eb_x;
  logic              w_a_nan, w_a_inf, w_a_zero;
  logic              w_b_nan, w_b_inf, w_b_zero;
  logic              w_inv, w_nan, w_inf;

  // A stage is blocked only when every stage after it is full and the
  // consumer is not taking the last one. Written flat rather than as a
  // ripple through w_adv so there is no combinational loop on the vector.
  function automatic logic f_blocked(input logic [STAGES-1:0] v, input logic rdy, input int k);
    logic blk;
    blk = !rdy;
    for (int j = k + 1; j < STAGES; j++) blk = blk & v[j];
    return blk;
  endfunction

  always_comb begin
    w_adv = '0;
    for (int k = 0; k < STAGES; k++) w_adv[k] = r_valid[k] && !f_blocked(r_valid, out_ready, k);
  end

  assign in_ready = rst || !r_valid[0] || w_adv[0];
  assign w_accept = in_valid && in_ready;

  // Operand decode
  assign w_ea     = a[MAN_W +: EXP_W];
  assign w_eb     = b[MAN_W +: EXP_W];
  assign w_fa     = a[MAN_W-1:0];
  assign w_fb     = b[MAN_W-1:0];
  assign w_a_nan  = (&w_ea) && (|w_fa);
  assign w_a_inf  = (&w_ea) && !(|w_fa);
  assign w_a_zero = (w_ea == '0) && (w_fa == '0);
  assign w_b_nan  = (&w_eb) && (|w_fb);
  assign w_b_inf  = (&w_eb) && !(|w_fb);
  assign w_b_zero = (w_eb == '0) && (w_fb == '0);
  assign w_inv    = (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero);
  assign w_nan    = w_a_nan || w_b_nan || w_inv;
  assign w_inf    = (w_a_inf || w_b_inf) && !w_nan;
  // Subnormals use exponent 1 with a zero implicit bit.
  assign w_ea_x   = (w_ea == '0) ? EW'(1) : EW'(w_ea);
  assign w_eb_x   = (w_eb == '0) ? EW'(1) : EW'(w_eb);

  always_comb begin
    w_in_pl         = '0;
    w_in_pl.sign    = a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
    w_in_pl.expo    = $signed(w_ea_x + w_eb_x - BIAS);
    w_in_pl.prod    = {(|w_ea), w_fa, (|w_eb), w_fb};
    w_in_pl.rm      = rm;
    w_in_pl.tag     = tag_i;
    w_in_pl.nan     = w_nan;
    w_in_pl.inf     = w_inf;
    w_in_pl.zero    = (w_a_zero || w_b_zero) && !w_nan && !w_inf;
    w_in_pl.invalid = w_inv;
  end

  assign w_prod = PROD_W'(r_pl[0].prod[PROD_W-1:SIG_W]) * PROD_W'(r_pl[0].prod[SIG_W-1:0]);

  always_comb begin
    w_s1_pl      = r_pl[0];
    w_s1_pl.prod = w_prod;
  end

  // Flush wins over load; a stage that empties also has its payload zeroed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) r_pl[k] <= '0;
    end else begin
      if (flush[0] || (!w_accept && w_adv[0])) begin
        r_valid[0] <= 1'b0;
        r_pl[0]    <= '0;
      end else if (w_accept) begin
        r_valid[0] <= 1'b1;
        r_pl[0]    <= w_in_pl;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (flush[k] || (!w_adv[k-1] && w_adv[k])) begin
          r_valid[k] <= 1'b0;
          r_pl[k]    <= '0;
        end else if (w_adv[k-1]) begin
          r_valid[k] <= 1'b1;
          r_pl[k]    <= (k == 1) ? w_s1_pl : r_pl[k-1];
        end
      end
    end
  end

  assign out_valid   = r_valid[STAGES-1];
  assign out_sign    = r_pl[STAGES-1].sign;
  assign out_exp     = r_pl[STAGES-1].expo;
  assign out_prod    = r_pl[STAGES-1].prod;
  assign out_rm      = r_pl[STAGES-1].rm;
  assign out_tag     = r_pl[STAGES-1].tag;
  assign out_nan     = r_pl[STAGES-1].nan;
  assign out_inf     = r_pl[STAGES-1].inf;
  assign out_zero    = r_pl[STAGES-1].zero;
  assign out_invalid = r_pl[STAGES-1].invalid;
  assign stage_valid = r_valid;

  always_comb begin
    stage_tag = '0;
    for (int k = 0; k < STAGES; k++) stage_tag[k] = r_pl[k].tag;
  end

endmodule

// File: tb/tb_fpmul_pipe_hs.sv
module tb_fpmul_pipe_hs;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       a, b;
  logic [2:0]        rm;
  logic [7:0]        tag_i;
  logic [1:0]        flush;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic signed [9:0] out_exp;
  logic [47:0]       out_prod;
  logic [2:0]        out_rm;
  logic [7:0]        out_tag;
  logic              out_nan, out_inf, out_zero, out_invalid;
  logic [1:0]        stage_valid;
  logic [1:0][7:0]   stage_tag;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fpmul_pipe_hs #(.EXP_W(8), .MAN_W(23), .STAGES(2), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rm(rm), .tag_i(tag_i), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_prod(out_prod),
    .out_rm(out_rm), .out_tag(out_tag),
    .out_nan(out_nan), .out_inf(out_inf), .out_zero(out_zero),
    .out_invalid(out_invalid),
    .stage_valid(stage_valid), .stage_tag(stage_tag)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] va, input logic [31:0] vb,
                        input logic [7:0] t);
    in_valid = v;
    a        = va;
    b        = vb;
    tag_i    = t;
  endtask

  // Issue one operation into an empty pipe with out_ready high; returns with
  // the result sitting in the last stage.
  task automatic one_op(input logic [31:0] va, input logic [31:0] vb, input logic [7:0] t);
    set_in(1'b1, va, vb, t);
    step();
    set_in(1'b0, 32'h0, 32'h0, 8'h00);
    step();
  endtask

  task automatic check_flags(input string tag, input logic n, input logic i,
                             input logic z, input logic inv);
    check_val({tag, "_nan"}, 64'(out_nan), 64'(n));
    check_val({tag, "_inf"}, 64'(out_inf), 64'(i));
    check_val({tag, "_zero"}, 64'(out_zero), 64'(z));
    check_val({tag, "_invalid"}, 64'(out_invalid), 64'(inv));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; rm = 3'd0; tag_i = '0;
    flush = '0; out_ready = 1'b1;

    // Reset state
    step(); step();
    check_val("rst_stage_valid", 64'(stage_valid), 64'd0);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_prod", 64'(out_prod), 64'd0);
    rst = 1'b0;
    step();

    // 1.5 * 2.0, latency of two edges
    rm = 3'b101;
    set_in(1'b1, 32'h3FC00000, 32'h40000000, 8'h01);
    #1 check_val("basic_in_ready", 64'(in_ready), 64'd1);
    step();
    check_val("basic_lat1_valid", 64'(out_valid), 64'd0);
    check_val("basic_lat1_stage", 64'(stage_valid), 64'd1);
    set_in(1'b0, 32'h0, 32'h0, 8'h00);
    rm = 3'b000;
    step();
    check_val("basic_valid", 64'(out_valid), 64'd1);
    check_val("basic_prod", 64'(out_prod), 64'h600000000000);
    check_val("basic_exp", 64'(out_exp), 64'd128);
    check_val("basic_sign", 64'(out_sign), 64'd0);
    check_val("basic_rm", 64'(out_rm), 64'd5);
    check_val("basic_tag", 64'(out_tag), 64'h01);
    check_flags("basic", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_val("basic_drain", 64'(out_valid), 64'd0);

    // inf * -0 -> invalid
    one_op(32'h7F800000, 32'h80000000, 8'h02);
    check_val("inv_sign", 64'(out_sign), 64'd1);
    check_flags("inv", 1'b1, 1'b0, 1'b0, 1'b1);
    step();

    // qNaN * 1.0
    one_op(32'h7FC00000, 32'h3F800000, 8'h03);
    check_flags("nan", 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    // inf * 2.0
    one_op(32'h7F800000, 32'h40000000, 8'h04);
    check_flags("inf", 1'b0, 1'b1, 1'b0, 1'b0);
    step();

    // 0 * 3.0
    one_op(32'h00000000, 32'h40400000, 8'h05);
    check_flags("zero", 1'b0, 1'b0, 1'b1, 1'b0);
    step();

    // smallest subnormal * 1.0: exp 1+127-127, sig 1 * 0x800000
    one_op(32'h00000001, 32'h3F800000, 8'h06);
    check_val("sub_exp", 64'(out_exp), 64'd1);
    check_val("sub_prod", 64'(out_prod), 64'h000000800000);
    check_flags("sub", 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // -2.0 * 3.0
    one_op(32'hC0000000, 32'h40400000, 8'h07);
    check_val("neg_sign", 64'(out_sign), 64'd1);
    check_val("neg_exp", 64'(out_exp), 64'd129);
    check_val("neg_prod", 64'(out_prod), 64'h600000000000);
    step();

    // Eight back-to-back operations
    for (int c = 0; c < 10; c++) begin
      if (c < 8) set_in(1'b1, 32'h3F800000, 32'h40000000, 8'(8'h10 + c));
      else       set_in(1'b0, 32'h0, 32'h0, 8'h00);
      #1;
      if (c < 8) check_val($sformatf("b2b_in_ready_%0d", c), 64'(in_ready), 64'd1);
      step();
      if (c >= 1 && c <= 8) begin
        check_val($sformatf("b2b_valid_%0d", c), 64'(out_valid), 64'd1);
        check_val($sformatf("b2b_tag_%0d", c), 64'(out_tag), 64'(8'h10 + c - 1));
      end else begin
        check_val($sformatf("b2b_idle_%0d", c), 64'(out_valid), 64'd0);
      end
    end

    // Stall: two accepts fill the pipe, then back-pressure
    out_ready = 1'b0;
    set_in(1'b1, 32'h3FC00000, 32'h40000000, 8'h20);
    #1 check_val("stall_acc0", 64'(in_ready), 64'd1);
    step();
    set_in(1'b1, 32'h3F800000, 32'h3F800000, 8'h21);
    #1 check_val("stall_acc1", 64'(in_ready), 64'd1);
    step();
    set_in(1'b1, 32'h40000000, 32'h40000000, 8'h22);
    for (int c = 0; c < 5; c++) begin
      check_val($sformatf("stall_in_ready_%0d", c), 64'(in_ready), 64'd0);
      check_val($sformatf("stall_valid_%0d", c), 64'(out_valid), 64'd1);
      check_val($sformatf("stall_tag_%0d", c), 64'(out_tag), 64'h20);
      check_val($sformatf("stall_prod_%0d", c), 64'(out_prod), 64'h600000000000);
      step();
    end
    out_ready = 1'b1;
    #1 check_val("release_in_ready", 64'(in_ready), 64'd1);
    step();
    set_in(1'b0, 32'h0, 32'h0, 8'h00);
    check_val("release_tag1", 64'(out_tag), 64'h21);
    check_val("release_valid1", 64'(out_valid), 64'd1);
    step();
    check_val("release_tag2", 64'(out_tag), 64'h22);
    check_val("release_valid2", 64'(out_valid), 64'd1);
    step();
    check_val("release_empty", 64'(out_valid), 64'd0);

    // flush[1] while the last stage is stalled: stage 1 emptied, stage 0 stays
    out_ready = 1'b0;
    set_in(1'b1, 32'h3F800000, 32'h3F800000, 8'h30); step();
    set_in(1'b1, 32'h3F800000, 32'h3F800000, 8'h31); step();
    set_in(1'b0, 32'h0, 32'h0, 8'h00);
    flush = 2'b10;
    step();
    flush = 2'b00;
    check_val("fl1_stage_valid", 64'(stage_valid), 64'b01);
    check_val("fl1_out_valid", 64'(out_valid), 64'd0);
    check_val("fl1_out_tag", 64'(out_tag), 64'h00);
    check_val("fl1_s0_tag", 64'(stage_tag[0]), 64'h31);
    out_ready = 1'b1;
    step();
    check_val("fl1_kept_tag", 64'(out_tag), 64'h31);
    check_val("fl1_kept_valid", 64'(out_valid), 64'd1);
    step();
    check_val("fl1_drain", 64'(out_valid), 64'd0);

    // flush[1] while stage 1 is accepting: incoming stage 0 item dropped
    out_ready = 1'b0;
    set_in(1'b1, 32'h3F800000, 32'h3F800000, 8'h40); step();
    set_in(1'b1, 32'h3F800000, 32'h3F800000, 8'h41); step();
    set_in(1'b0, 32'h0, 32'h0, 8'h00);
    out_ready = 1'b1;
    flush = 2'b10;
    step();
    flush = 2'b00;
    check_val("fl1acc_stage_valid", 64'(stage_valid), 64'b00);
    check_val("fl1acc_out_valid", 64'(out_valid), 64'd0);

    // flush[0] together with an accept: the input is consumed and dropped
    set_in(1'b1, 32'h3F800000, 32'h3F800000, 8'h50);
    flush = 2'b01;
    #1 check_val("fl0_in_ready", 64'(in_ready), 64'd1);
    step();
    set_in(1'b0, 32'h0, 32'h0, 8'h00);
    flush = 2'b00;
    check_val("fl0_stage_valid", 64'(stage_valid), 64'b00);
    step();
    check_val("fl0_out_valid", 64'(out_valid), 64'd0);

    // Reset with two items in flight
    out_ready = 1'b0;
    set_in(1'b1, 32'h3F800000, 32'h3F800000, 8'h60); step();
    set_in(1'b1, 32'h3F800000, 32'h3F800000, 8'h61); step();
    set_in(1'b0, 32'h0, 32'h0, 8'h00);
    check_val("mrst_full", 64'(stage_valid), 64'b11);
    rst = 1'b1;
    #1 check_val("mrst_in_ready_during", 64'(in_ready), 64'd1);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    check_val("mrst_stage_valid", 64'(stage_valid), 64'b00);
    check_val("mrst_out_prod", 64'(out_prod), 64'd0);
    for (int c = 0; c < 3; c++) begin
      check_val($sformatf("mrst_no_out_%0d", c), 64'(out_valid), 64'd0);
      step();
    end
    one_op(32'h40000000, 32'h40000000, 8'h70);
    check_val("mrst_new_valid", 64'(out_valid), 64'd1);
    check_val("mrst_new_tag", 64'(out_tag), 64'h70);
    check_val("mrst_new_exp", 64'(out_exp), 64'd129);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
